prbs9_checker: RTL

Single-lane PRBS9 (x^9 + x^5 + 1) bit-error-rate checker for the I/Q test path. It consumes one PRBS bit stream (I or Q), either straight from the `prbsQI` generator outputs or after the tx/rx loopback, and instantiates once per lane. It aligns to the stream without knowing the seed or latency, then counts checked bits and bit errors. It drops lock and re-acquires on sustained error bursts.

---
 rtl/prbs9_checker.sv | 137 +++++++++++++
 1 files changed

// File: rtl/prbs9_checker.sv
// prbs9_checker: single-lane PRBS9 (x^9 + x^5 + 1) bit-error-rate checker.
// Self-aligns to an unknown-seed, unknown-latency stream, then counts checked
// bits and bit errors. Drops lock and re-acquires after sustained error bursts.
//
// Parameters:
//   CNT_W    width of the bit and error counters
//   LOCK_CNT consecutive matching bits needed to declare lock
//   WIN      loss-of-lock observation window, in accepted bits
//   LOSS_THR lock drops when the window error count exceeds this value
// Ports:
//   clock       rising-edge clock
//   i_reset     synchronous active-high reset
//   i_enable    block enable
//   i_valid     i_bit is valid this cycle
//   i_clear     synchronous clear of both counters (lock untouched)
//   i_bit       received PRBS bit
//   o_locked    checker is aligned
//   o_err_flag  one-cycle pulse per mismatched bit while locked
//   o_bit_count saturating count of bits checked while locked
//   o_err_count saturating count of errors while locked
module prbs9_checker #(
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned LOCK_CNT = 16,
   parameter int unsigned WIN      = 128,
   parameter int unsigned LOSS_THR = 16
) (
   input  logic             clock,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic             i_valid,
   input  logic             i_clear,
   input  logic             i_bit,
   output logic             o_locked,
   output logic             o_err_flag,
   output logic [CNT_W-1:0] o_bit_count,
   output logic [CNT_W-1:0] o_err_count
);

   localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
   // Wide enough for win_cnt (0..WIN-1) and for win_err, which must hold WIN.
   localparam int unsigned WinW   = $clog2(WIN + 1);

   localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_CNT - 1);
   localparam logic [WinW-1:0]   WinLast   = WinW'(WIN - 1);

   typedef enum logic [0:0] {StSearch, StLocked} state_t;

   state_t            state;
   logic [8:0]        h;          // h[0] is the newest bit
   logic [3:0]        fill_cnt;
   logic [MatchW-1:0] match_cnt;
   logic [WinW-1:0]   win_cnt;
   logic [WinW-1:0]   win_err;

   logic        accept;
   logic        pred;
   logic        err_bit;
   logic [31:0] win_sum;

   always_comb begin
      accept  = i_enable & i_valid;
      // s[n] = s[n-5] ^ s[n-9]
      pred    = h[4] ^ h[8];
      err_bit = i_bit ^ pred;
      // Window errors including the sample being accepted now.
      win_sum = 32'(win_err) + 32'(err_bit);
   end

   always_ff @(posedge clock) begin
      if (i_reset) begin
         state       <= StSearch;
         h           <= '0;
         fill_cnt    <= '0;
         match_cnt   <= '0;
         win_cnt     <= '0;
         win_err     <= '0;
         o_locked    <= 1'b0;
         o_err_flag  <= 1'b0;
         o_bit_count <= '0;
         o_err_count <= '0;
      end else begin
         o_err_flag <= 1'b0;
         if (accept) begin
            unique case (state)
               StSearch: begin
                  h <= {h[7:0], i_bit};
                  if (fill_cnt != 4'd9) begin
                     fill_cnt <= fill_cnt + 4'd1;
                  end else if (!err_bit && (h != '0)) begin
                     // An all-zero history predicts zero forever; never lock on it.
                     match_cnt <= match_cnt + 1'b1;
                     if (match_cnt == MatchLast) begin
                        state    <= StLocked;
                        o_locked <= 1'b1;
                        win_cnt  <= '0;
                        win_err  <= '0;
                     end
                  end else begin
                     match_cnt <= '0;
                  end
               end
               StLocked: begin
                  // Free-run the local copy so input errors do not propagate.
                  h          <= {h[7:0], pred};
                  o_err_flag <= err_bit;
                  if (o_bit_count != '1) begin
                     o_bit_count <= o_bit_count + 1'b1;
                  end
                  if (err_bit && (o_err_count != '1)) begin
                     o_err_count <= o_err_count + 1'b1;
                  end
                  if (win_cnt == WinLast) begin
                     win_cnt <= '0;
                     win_err <= '0;
                     if (win_sum > LOSS_THR) begin
                        state     <= StSearch;
                        o_locked  <= 1'b0;
                        match_cnt <= '0;
                        fill_cnt  <= '0;
                     end
                  end else begin
                     win_cnt <= win_cnt + 1'b1;
                     win_err <= win_err + WinW'(err_bit);
                  end
               end
               default: ;
            endcase
         end
         // Clear overrides any count update from a sample in the same cycle.
         if (i_clear) begin
            o_bit_count <= '0;
            o_err_count <= '0;
         end
      end
   end

endmodule
